debinarization_output: RTL

DEBINARIZATION_OUTPUT -- requirements
Module: debinarization_output

---
 rtl/debinarization_output.sv | 112 +++++++++++
 1 files changed

// File: rtl/debinarization_output.sv
// Rebuilds signed pixels from thermometer-coded binary channels, one kernel element per cycle.
// Each pixel is the element's popcount minus half the channel count, saturated to BIT_WIDTH.
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 9
`endif
`ifndef CHANNEL_CNT
`define CHANNEL_CNT 256
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif

module debinarization_output #(
  parameter int KERNEL_SIZE = `KERNEL_SIZE,
  parameter int CHANNEL_CNT = `CHANNEL_CNT,
  parameter int BIT_WIDTH   = `BIT_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [KERNEL_SIZE-1:0][CHANNEL_CNT-1:0] bin_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [KERNEL_SIZE-1:0][BIT_WIDTH-1:0]   pixel_out,
  output logic                                    therm_err
);

  localparam int CW = $clog2(CHANNEL_CNT + 1);
  localparam int IW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic signed [31:0] MAX_V = 2 ** (BIT_WIDTH - 1) - 1;
  localparam logic signed [31:0] MIN_V = -(2 ** (BIT_WIDTH - 1));
  localparam logic [IW-1:0] LAST_IDX = IW'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                                  state;
  logic [IW-1:0]                           idx;
  logic [KERNEL_SIZE-1:0][CHANNEL_CNT-1:0] kernel;

  logic [CHANNEL_CNT-1:0]  elem;
  logic [CHANNEL_CNT-1:0]  elem_inc;
  logic [CW-1:0]           cnt;
  logic                    non_therm;
  logic signed [31:0]      diff;
  logic [BIT_WIDTH-1:0]    value;

  // Conversion datapath for the element selected by idx.
  always_comb begin
    elem = kernel[idx];
    cnt  = '0;
    for (int i = 0; i < CHANNEL_CNT; i++) begin
      cnt = cnt + CW'(elem[i]);
    end
    // A thermometer code plus one is a single power of two (or wraps to zero),
    // so it shares no set bit with the original value.
    elem_inc  = elem + {{(CHANNEL_CNT-1){1'b0}}, 1'b1};
    non_therm = (elem & elem_inc) != '0;
    diff      = $signed(32'(cnt)) - $signed(32'(CHANNEL_CNT / 2));
    if (diff > MAX_V)      value = MAX_V[BIT_WIDTH-1:0];
    else if (diff < MIN_V) value = MIN_V[BIT_WIDTH-1:0];
    else                   value = diff[BIT_WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only; the captured
  // kernel is deliberately left out of reset since it is always reloaded
  // before it is read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      pixel_out <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      therm_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            kernel   <= bin_in;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          pixel_out[idx] <= value;
          if (non_therm) therm_err <= 1'b1;
          if (idx == LAST_IDX) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
